serial_addsub_acc: RTL and testbench

Parametrised multi-cycle adder/subtractor/accumulator for the Tiny Tapeout user slot. It replaces the single-cycle fixed-width combinational adder. Operands are accepted with a valid/ready handshake and summed DIGIT bits per clock, least-significant digit first, through a shared carry register. The block adds subtract, unsigned-saturate and accumulate modes, and reports carry and signed-overflow flags. Results are held until the consumer takes them.

---
 rtl/serial_addsub_acc.sv | 122 ++++++++++++
 tb/tb_serial_addsub_acc.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_acc.sv
// serial_addsub_acc: digit-serial add/sub/saturate/accumulate with valid/ready handshake
module serial_addsub_acc #(
  parameter int WIDTH = 6,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [1:0]       in_mode,
  input  logic             in_acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CW = NSTEP > 1 ? $clog2(NSTEP) : 1;
  localparam logic [1:0] M_SUB = 2'b01;
  localparam logic [1:0] M_ACC = 2'b10;
  localparam logic [1:0] M_SAT = 2'b11;

  if (WIDTH < 2 || WIDTH % DIGIT != 0) begin : g_bad_params
    $error("serial_addsub_acc: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d, sum_q, sum_d, acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, sat_q, sat_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [DIGIT-1:0] dsum;
  logic             dcarry;
  logic [WIDTH-1:0] raw;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

  // one digit of the sum plus the full raw result as it would stand after this step
  always_comb begin
    {dcarry, dsum} = {1'b0, x_q[cnt_q*DIGIT +: DIGIT]} + {1'b0, y_q[cnt_q*DIGIT +: DIGIT]}
                     + (DIGIT+1)'(carry_q);
    raw = res_q;
    raw[cnt_q*DIGIT +: DIGIT] = dsum;
  end

  // handshake FSM: capture operands on accept, step digits, publish flags on the last step
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    sum_d   = sum_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sat_d   = sat_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = RUN;
        x_d     = in_mode == M_ACC ? (in_acc_clr ? '0 : acc_q) : in_a;
        y_d     = in_mode == M_SUB ? ~in_b : in_b;
        carry_d = in_mode == M_SUB ? ~in_cin : in_cin;
        sat_d   = in_mode == M_SAT;
        cnt_d   = '0;
      end
      RUN: begin
        res_d   = raw;
        carry_d = dcarry;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NSTEP-1)) begin
          state_d = DONE;
          sum_d   = sat_q && dcarry ? '1 : raw;
          acc_d   = sat_q && dcarry ? '1 : raw;
          cout_d  = dcarry;
          ovf_d   = sat_q ? dcarry : (x_q[WIDTH-1] == y_q[WIDTH-1]) && (raw[WIDTH-1] != x_q[WIDTH-1]);
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sat_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sat_q   <= sat_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_serial_addsub_acc.sv
// tb_serial_addsub_acc: vector table, corner sequences and random ops against an arithmetic model
module tb_serial_addsub_acc;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] in_a = '0, in_b = '0;
  logic       in_cin = 1'b0, in_acc_clr = 1'b0;
  logic [1:0] in_mode = '0;
  logic       iv [3];
  logic       ordy [3];
  logic       ir [3];
  logic       ov [3];
  logic [5:0] osum [3];
  logic       ocout [3];
  logic       oovf [3];
  int         ncmp = 0, nerr = 0;
  int         macc [3];
  int         nstep [3] = '{3, 6, 1};

  always #5 clk = ~clk;

  serial_addsub_acc #(.WIDTH(6), .DIGIT(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_mode(in_mode), .in_acc_clr(in_acc_clr), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_sum(osum[0]), .out_cout(ocout[0]), .out_ovf(oovf[0]));
  serial_addsub_acc #(.WIDTH(6), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_mode(in_mode), .in_acc_clr(in_acc_clr), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_sum(osum[1]), .out_cout(ocout[1]), .out_ovf(oovf[1]));
  serial_addsub_acc #(.WIDTH(6), .DIGIT(6)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .in_mode(in_mode), .in_acc_clr(in_acc_clr), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_sum(osum[2]), .out_cout(ocout[2]), .out_ovf(oovf[2]));

  typedef struct {
    logic [1:0] mode;
    logic [5:0] a, b;
    logic       cin, clr;
    logic [5:0] sum;
    logic       cout, ovf;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sg(input int v);
    return v >= 32 ? v - 64 : v;
  endfunction

  // reference: plain integer arithmetic on the operation's meaning
  task automatic model(input int k, input int m, input int a, input int b, input int ci,
                       input int cl, output int s, output int c, output int o);
    int t, st, x;
    x = (m == 2) ? (cl ? 0 : macc[k]) : a;
    if (m == 1) begin
      s  = (a - b - ci + 128) % 64;
      c  = (a >= b + ci) ? 1 : 0;
      st = sg(a) - sg(b) - ci;
      o  = (st > 31 || st < -32) ? 1 : 0;
    end else if (m == 3) begin
      t = a + b + ci;
      s = t >= 64 ? 63 : t;
      c = t >= 64 ? 1 : 0;
      o = c;
    end else begin
      t  = x + b + ci;
      s  = t % 64;
      c  = t / 64;
      st = sg(x) + sg(b) + ci;
      o  = (st > 31 || st < -32) ? 1 : 0;
    end
    macc[k] = s;
  endtask

  task automatic do_op(input int k, input logic [1:0] m, input logic [5:0] a, input logic [5:0] b,
                       input logic ci, input logic cl, output int lat);
    int n = 0;
    while (!ir[k] && n < 50) begin @(negedge clk); n++; end
    if (!ir[k]) begin chk("accept_timeout", 0, 1); lat = -1; return; end
    in_mode = m; in_a = a; in_b = b; in_cin = ci; in_acc_clr = cl; iv[k] = 1'b1;
    @(negedge clk);
    iv[k] = 1'b0;
    in_a = 6'($urandom); in_b = 6'($urandom); in_mode = 2'($urandom);
    in_cin = 1'($urandom); in_acc_clr = 1'($urandom);
    lat = 0;
    while (!ov[k] && lat < 40) begin @(negedge clk); lat++; end
    if (!ov[k]) chk("result_timeout", 0, 1);
  endtask

  task automatic release_out(input int k, input int hold, input int exp_sum);
    repeat (hold) @(negedge clk);
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
    chk("valid_drop", int'(ov[k]), 0);
    chk("sum_kept", int'(osum[k]), exp_sum);
  endtask

  task automatic run_check(input int k, input int m, input int a, input int b, input int ci,
                           input int cl, input int hold);
    int s, c, o, lat;
    model(k, m, a, b, ci, cl, s, c, o);
    do_op(k, 2'(m), 6'(a), 6'(b), 1'(ci), 1'(cl), lat);
    chk($sformatf("rnd%0d_m%0d_sum", k, m), int'(osum[k]), s);
    chk($sformatf("rnd%0d_m%0d_cout", k, m), int'(ocout[k]), c);
    chk($sformatf("rnd%0d_m%0d_ovf", k, m), int'(oovf[k]), o);
    chk($sformatf("rnd%0d_lat", k), lat, nstep[k]);
    release_out(k, hold, s);
  endtask

  initial begin
    int lat, s, c, o;
    for (int k = 0; k < 3; k++) begin iv[k] = 1'b0; ordy[k] = 1'b0; macc[k] = 0; end
    tbl[0]  = '{2'd0, 6'd45, 6'd30, 1'b1, 1'b0, 6'd12, 1'b1, 1'b0};
    tbl[1]  = '{2'd0, 6'd31, 6'd1,  1'b0, 1'b0, 6'd32, 1'b0, 1'b1};
    tbl[2]  = '{2'd1, 6'd10, 6'd20, 1'b0, 1'b0, 6'd54, 1'b0, 1'b0};
    tbl[3]  = '{2'd1, 6'd5,  6'd5,  1'b1, 1'b0, 6'd63, 1'b0, 1'b0};
    tbl[4]  = '{2'd1, 6'd32, 6'd1,  1'b0, 1'b0, 6'd31, 1'b1, 1'b1};
    tbl[5]  = '{2'd3, 6'd40, 6'd30, 1'b0, 1'b0, 6'd63, 1'b1, 1'b1};
    tbl[6]  = '{2'd3, 6'd20, 6'd30, 1'b0, 1'b0, 6'd50, 1'b0, 1'b0};
    tbl[7]  = '{2'd2, 6'd55, 6'd10, 1'b0, 1'b1, 6'd10, 1'b0, 1'b0};
    tbl[8]  = '{2'd2, 6'd3,  6'd7,  1'b1, 1'b0, 6'd18, 1'b0, 1'b0};
    tbl[9]  = '{2'd0, 6'd1,  6'd1,  1'b0, 1'b0, 6'd2,  1'b0, 1'b0};
    tbl[10] = '{2'd2, 6'd60, 6'd0,  1'b0, 1'b0, 6'd2,  1'b0, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_ready", int'(ir[0]), 0);
    chk("rst_valid", int'(ov[0]), 0);
    chk("rst_sum", int'(osum[0]), 0);
    chk("rst_cout", int'(ocout[0]), 0);
    chk("rst_ovf", int'(oovf[0]), 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", int'(ir[0]), 1);

    for (int i = 0; i < 11; i++) begin
      model(0, int'(tbl[i].mode), int'(tbl[i].a), int'(tbl[i].b), int'(tbl[i].cin),
            int'(tbl[i].clr), s, c, o);
      do_op(0, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].clr, lat);
      chk($sformatf("tbl%0d_sum", i), int'(osum[0]), int'(tbl[i].sum));
      chk($sformatf("tbl%0d_cout", i), int'(ocout[0]), int'(tbl[i].cout));
      chk($sformatf("tbl%0d_ovf", i), int'(oovf[0]), int'(tbl[i].ovf));
      chk($sformatf("tbl%0d_lat", i), lat, 3);
      release_out(0, 0, int'(tbl[i].sum));
    end

    model(0, 0, 3, 4, 0, 0, s, c, o);
    do_op(0, 2'd0, 6'd3, 6'd4, 1'b0, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      iv[0] = ~iv[0];
      in_a = 6'($urandom); in_b = 6'($urandom); in_mode = 2'($urandom);
      @(negedge clk);
      chk("bp_valid", int'(ov[0]), 1);
      chk("bp_sum", int'(osum[0]), 7);
      chk("bp_ready", int'(ir[0]), 0);
    end
    iv[0] = 1'b0;
    release_out(0, 0, 7);
    chk("bp_ready_after", int'(ir[0]), 1);
    model(0, 2, 0, 0, 0, 0, s, c, o);
    do_op(0, 2'd2, 6'd9, 6'd0, 1'b0, 1'b0, lat);
    chk("bp_acc_kept", int'(osum[0]), 7);
    release_out(0, 0, 7);

    in_mode = 2'd0; in_a = 6'd45; in_b = 6'd30; in_cin = 1'b1; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", int'(ov[0]), 0);
    chk("abort_sum", int'(osum[0]), 0);
    chk("abort_cout", int'(ocout[0]), 0);
    chk("abort_ovf", int'(oovf[0]), 0);
    chk("abort_ready_in_rst", int'(ir[0]), 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) macc[k] = 0;
    #1 chk("abort_ready", int'(ir[0]), 1);
    repeat (4) @(negedge clk);
    chk("abort_no_result", int'(ov[0]), 0);
    do_op(0, 2'd2, 6'd0, 6'd0, 1'b0, 1'b0, lat);
    chk("abort_acc_zero", int'(osum[0]), 0);
    release_out(0, 0, 0);

    for (int k = 1; k < 3; k++) begin
      model(k, 0, 45, 30, 1, 0, s, c, o);
      do_op(k, 2'd0, 6'd45, 6'd30, 1'b1, 1'b0, lat);
      chk($sformatf("d%0d_sum", k), int'(osum[k]), 12);
      chk($sformatf("d%0d_cout", k), int'(ocout[k]), 1);
      chk($sformatf("d%0d_lat", k), lat, nstep[k]);
      release_out(k, 0, 12);
    end

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < (k == 0 ? 40 : 15); i++)
        run_check(k, int'($urandom_range(0, 3)), int'($urandom_range(0, 63)),
                  int'($urandom_range(0, 63)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
